// File: rtl/pwm_3l_carrier_mod.sv
// Carrier-based three-level PWM modulator.
//
// A symmetric triangular carrier is compared against a signed, shadow-latched
// reference. The result is a level command (0 = zero, 1 = P, 2 = N) for the
// ANPC commutation FSM. Two constraints apply to that command:
//   - each level must dwell for a minimum time;
//   - a P<->N change always passes through zero.
// Carrier peak and valley events are emitted as one-clk sync pulses.
//
// Optional build macro PWM3L_DOUBLE_UPDATE_EN: when defined, the reference
// shadow is also reloaded at the carrier peak. The period shadow is always
// reloaded at the valley only.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   ce          clock enable; the carrier and the dwell timer advance only when ce=1
//   en          modulator enable; en=0 forces the zero level and restarts the carrier
//   period      carrier half-period in ticks; shadow-loaded at the valley
//   ref_val     signed modulation reference; shadow-loaded at the valley
//               (named ref_val because "ref" is a reserved word)
//   t_min       minimum dwell per output level, in ce ticks
//   v_lev       level command: 0 = zero, 1 = P, 2 = N; the value 3 is never driven
//   sync_peak   one-clk pulse at the carrier peak
//   sync_valley one-clk pulse at the carrier valley
module pwm_3l_carrier_mod #(
  parameter int CNT_W = 10,
  parameter int REF_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [REF_W-1:0] ref_val,
  input  logic [CNT_W-1:0] t_min,
  output logic [1:0]       v_lev,
  output logic             sync_peak,
  output logic             sync_valley
);

  // Common width for the magnitude/count comparison. REF_W+1 bits keep
  // |most negative reference| from overflowing.
  localparam int MW = (REF_W + 1 > CNT_W + 1) ? REF_W + 1 : CNT_W + 1;

  localparam logic [1:0] LevZero = 2'd0;
  localparam logic [1:0] LevP    = 2'd1;
  localparam logic [1:0] LevN    = 2'd2;

`ifdef PWM3L_DOUBLE_UPDATE_EN
  localparam bit DoubleUpdate = 1'b1;
`else
  localparam bit DoubleUpdate = 1'b0;
`endif

  typedef enum logic {
    StUp,
    StDown
  } dir_e;

  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d;
  logic [REF_W-1:0] ref_sh_q, ref_sh_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       lev_q, lev_d;
  logic             peak_q, peak_d;
  logic             valley_q, valley_d;

  logic [CNT_W:0] cnt_inc;
  logic [MW-1:0]  cnt_ext;
  logic [MW-1:0]  psh_ext;
  logic [MW-1:0]  ref_ext;
  logic [MW-1:0]  mag;
  logic [MW-1:0]  mag_sat;
  logic           ref_neg;
  logic [1:0]     target;

  // Raw level target from the current carrier count and reference shadow.
  always_comb begin
    ref_neg = ref_sh_q[REF_W-1];
    cnt_ext = {{(MW - CNT_W){1'b0}}, count_q};
    psh_ext = {{(MW - CNT_W){1'b0}}, period_sh_q};
    ref_ext = {{(MW - REF_W){ref_sh_q[REF_W-1]}}, ref_sh_q};
    mag     = ref_neg ? (~ref_ext + MW'(1)) : ref_ext;
    mag_sat = (mag > psh_ext) ? psh_ext : mag;
    target  = LevZero;
    // A zero reference gives mag=0, which never exceeds the count.
    if (mag_sat > cnt_ext) begin
      target = ref_neg ? LevN : LevP;
    end
  end

  assign cnt_inc = {1'b0, count_q} + (CNT_W + 1)'(1);

  always_comb begin
    dir_d       = dir_q;
    count_d     = count_q;
    period_sh_d = period_sh_q;
    ref_sh_d    = ref_sh_q;
    hold_d      = hold_q;
    lev_d       = lev_q;
    peak_d      = 1'b0;
    valley_d    = 1'b0;

    if (!en) begin
      // Held in zero with the carrier parked at 0 and the shadows tracking
      // the inputs, so re-enabling starts a clean cycle.
      lev_d       = LevZero;
      hold_d      = '0;
      count_d     = '0;
      dir_d       = StUp;
      period_sh_d = period;
      ref_sh_d    = ref_val;
    end else if (ce) begin
      // Dwell filter: a pending target is only looked at once the hold expires.
      if (hold_q != '0) begin
        hold_d = hold_q - CNT_W'(1);
      end else if (target != lev_q) begin
        hold_d = t_min;
        // Two different nonzero levels mean P<->N: step through zero first.
        if (lev_q != LevZero && target != LevZero) begin
          lev_d = LevZero;
        end else begin
          lev_d = target;
        end
      end

      // Carrier. The state is evaluated after the comparison above, which gives
      // v_lev its one-clk lag.
      unique case (dir_q)
        StUp: begin
          if (cnt_inc >= {1'b0, period_sh_q}) begin
            count_d = period_sh_q;
            dir_d   = StDown;
            peak_d  = 1'b1;
            if (DoubleUpdate) begin
              ref_sh_d = ref_val;
            end
          end else begin
            count_d = cnt_inc[CNT_W-1:0];
          end
        end
        StDown: begin
          if (count_q <= CNT_W'(1)) begin
            count_d     = '0;
            dir_d       = StUp;
            valley_d    = 1'b1;
            period_sh_d = period;
            ref_sh_d    = ref_val;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        default: begin
          dir_d = StUp;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q       <= StUp;
      count_q     <= '0;
      period_sh_q <= '0;
      ref_sh_q    <= '0;
      hold_q      <= '0;
      lev_q       <= LevZero;
      peak_q      <= 1'b0;
      valley_q    <= 1'b0;
    end else begin
      dir_q       <= dir_d;
      count_q     <= count_d;
      period_sh_q <= period_sh_d;
      ref_sh_q    <= ref_sh_d;
      hold_q      <= hold_d;
      lev_q       <= lev_d;
      peak_q      <= peak_d;
      valley_q    <= valley_d;
    end
  end

  assign v_lev       = lev_q;
  assign sync_peak   = peak_q;
  assign sync_valley = valley_q;

endmodule

// File: tb/tb_pwm_3l_carrier_mod.sv
module tb_pwm_3l_carrier_mod;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic              en;
  logic [9:0]        period;
  logic signed [10:0] ref_val;
  logic [9:0]        t_min;
  logic [1:0]        v_lev;
  logic              sync_peak;
  logic              sync_valley;

  int total = 0;
  int bad   = 0;

  pwm_3l_carrier_mod dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .en         (en),
    .period     (period),
    .ref_val    (ref_val),
    .t_min      (t_min),
    .v_lev      (v_lev),
    .sync_peak  (sync_peak),
    .sync_valley(sync_valley)
  );

  always #5 clk = ~clk;

  // Reference model, written directly from the behavioural description.
  int m_count, m_psh, m_rsh, m_hold, m_lev;
  bit m_down, m_sp, m_sv;
  logic [3:0] expq[$];

  // Observation statistics.
  int n_p, n_n, n_sp, n_sv;
  int prev_lev, run_len;
  bit armed;

  function automatic void model_reset();
    m_count = 0; m_psh = 0; m_rsh = 0; m_hold = 0; m_lev = 0;
    m_down = 0; m_sp = 0; m_sv = 0;
  endfunction

  function automatic void model_step();
    int mag, tgt;
    m_sp = 0;
    m_sv = 0;
    if (!en) begin
      m_lev = 0; m_hold = 0; m_count = 0; m_down = 0;
      m_psh = int'(period); m_rsh = int'(ref_val);
    end else if (ce) begin
      mag = (m_rsh < 0) ? -m_rsh : m_rsh;
      if (mag > m_psh) mag = m_psh;
      tgt = (mag > m_count) ? ((m_rsh < 0) ? 2 : 1) : 0;
      if (m_hold > 0) m_hold--;
      else if (tgt != m_lev) begin
        m_lev  = (m_lev * tgt != 0) ? 0 : tgt;
        m_hold = int'(t_min);
      end
      if (!m_down) begin
        if (m_count + 1 >= m_psh) begin
          m_count = m_psh; m_down = 1; m_sp = 1;
`ifdef PWM3L_DOUBLE_UPDATE_EN
          m_rsh = int'(ref_val);
`endif
        end else m_count++;
      end else begin
        if (m_count <= 1) begin
          m_count = 0; m_down = 0; m_sv = 1;
          m_psh = int'(period); m_rsh = int'(ref_val);
        end else m_count--;
      end
    end
  endfunction

  task automatic clear_counts();
    n_p = 0; n_n = 0; n_sp = 0; n_sv = 0;
  endtask

  // Runs n clocks; toggle=1 drives ce as 1,0,1,0...
  task automatic run(input int n, input bit toggle);
    logic [3:0] got, exp;
    int min_run;
    armed = 0;
    for (int i = 0; i < n; i++) begin
      ce = toggle ? ((i % 2) == 0) : 1'b1;
      model_step();
      expq.push_back({m_lev[1:0], m_sp, m_sv});
      @(posedge clk);
      #1;
      got = {v_lev, sync_peak, sync_valley};
      exp = expq.pop_front();
      total++;
      assert (got === exp) else begin
        bad++;
        $error("FAIL step lev/peak/valley got=%b exp=%b t=%0t", got, exp, $time);
      end
      total++;
      assert (!((prev_lev == 1 && v_lev == 2) || (prev_lev == 2 && v_lev == 1))) else begin
        bad++;
        $error("FAIL direct_pn prev=%0d now=%0d exp=via_zero t=%0t", prev_lev, v_lev, $time);
      end
      min_run = (int'(t_min) + 1) * (toggle ? 2 : 1);
      if (!en) begin
        armed = 0; run_len = 0;
      end else if (int'(v_lev) != prev_lev) begin
        if (armed) begin
          total++;
          assert (run_len >= min_run) else begin
            bad++;
            $error("FAIL dwell run=%0d exp>=%0d t=%0t", run_len, min_run, $time);
          end
        end
        armed = 1; run_len = 1;
      end else run_len++;
      prev_lev = int'(v_lev);
      n_p  += (v_lev == 2'd1) ? 1 : 0;
      n_n  += (v_lev == 2'd2) ? 1 : 0;
      n_sp += sync_peak ? 1 : 0;
      n_sv += sync_valley ? 1 : 0;
    end
  endtask

  // Parks the carrier with en=0 for one clk so the shadows load, then re-enables.
  task automatic restart(input int p, input int r, input int tm);
    period  = p[9:0];
    ref_val = r[10:0];
    t_min   = tm[9:0];
    en      = 1'b0;
    run(1, 0);
    en = 1'b1;
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; en = 1'b0;
    period = 10'd4; ref_val = '0; t_min = '0;
    prev_lev = 0; run_len = 0; armed = 0;
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check_int("reset_outputs", int'({v_lev, sync_peak, sync_valley}), 0);
    rst = 1'b0;

    // Carrier timing, zero reference.
    restart(4, 0, 0);
    clear_counts();
    run(24, 0);
    check_int("carrier_peaks", n_sp, 3);
    check_int("carrier_valleys", n_sv, 3);
    check_int("zero_ref_levels", n_p + n_n, 0);

    // +/-2 reference: 3 active ticks per 8-tick cycle.
    restart(4, 2, 0);
    clear_counts();
    run(16, 0);
    check_int("pos_ref_p_ticks", n_p, 6);
    check_int("pos_ref_n_ticks", n_n, 0);
    restart(4, -2, 0);
    clear_counts();
    run(16, 0);
    check_int("neg_ref_n_ticks", n_n, 6);

    // Saturation: mag clips to period_sh, so only the peak count drops to zero.
    restart(4, -1024, 0);
    clear_counts();
    run(16, 0);
    check_int("sat_neg_n_ticks", n_n, 14);
    restart(4, 1023, 0);
    clear_counts();
    run(16, 0);
    check_int("sat_pos_p_ticks", n_p, 14);

    // Sign reversal under dwell.
    restart(8, 8, 3);
    run(4, 0);
    ref_val = -11'sd8;
    clear_counts();
    run(48, 0);
    check_int("reversal_reaches_n", (n_n > 0) ? 1 : 0, 1);
    ref_val = 11'sd8;
    run(40, 0);

    // Dwell filter at full and half tick rate.
    restart(8, 1, 5);
    clear_counts();
    run(64, 0);
    check_int("dwell_has_p", (n_p > 0) ? 1 : 0, 1);
    restart(8, 1, 5);
    run(128, 1);

    // en dropped while in P.
    restart(4, 2, 0);
    run(1, 0);
    check_int("pre_drop_p", int'(v_lev), 1);
    en = 1'b0;
    run(1, 0);
    check_int("en_drop_zero", int'(v_lev), 0);
    en = 1'b1;
    clear_counts();
    run(8, 0);
    check_int("restart_valley", n_sv, 1);
    check_int("restart_peak", n_sp, 1);

    // Asynchronous reset mid-cycle.
    restart(4, 2, 0);
    run(1, 0);
    rst = 1'b1;
    #1;
    check_int("async_rst_outputs", int'({v_lev, sync_peak, sync_valley}), 0);
    @(posedge clk);
    #1;
    check_int("rst_held_outputs", int'({v_lev, sync_peak, sync_valley}), 0);
    rst = 1'b0;
    model_reset();
    prev_lev = 0;

    // Reference step before the peak.
    restart(8, 2, 0);
    clear_counts();
    run(1, 0);
    ref_val = 11'sd6;
    run(15, 0);
`ifdef PWM3L_DOUBLE_UPDATE_EN
    check_int("mid_cycle_update", n_p, 7);
`else
    check_int("mid_cycle_update", n_p, 3);
`endif
    run(16, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
